exe_sched: RTL and testbench

EXE_SCHED -- requirements
Module: exe_sched

---
 rtl/exe_sched_if.sv | 30 +++
 rtl/exe_sched.sv | 123 ++++++++++++
 tb/tb_exe_sched.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/exe_sched_if.sv
// Scheduler <-> controller signal bundle for exe_sched.
// All control lines are single-cycle pulses (no valid/ready pair): run, out_fin
// in; s_init, k_init, k_fin, done out. k_len/tile_num are sampled only with an accepted run.
interface exe_sched_if #(
  parameter int K_W = 8,
  parameter int T_W = 6
);
  logic           run;
  logic [K_W-1:0] k_len;
  logic [T_W-1:0] tile_num;
  logic           out_fin;
  logic           s_init;
  logic           k_init;
  logic           k_fin;
  logic [K_W-1:0] k_cnt;
  logic           busy;
  logic           done;
  logic           err;
  logic [15:0]    stall_cnt;

  modport master (
    output run, k_len, tile_num, out_fin,
    input  s_init, k_init, k_fin, k_cnt, busy, done, err, stall_cnt
  );

  modport slave (
    input  run, k_len, tile_num, out_fin,
    output s_init, k_init, k_fin, k_cnt, busy, done, err, stall_cnt
  );
endinterface

// File: rtl/exe_sched.sv
// Execution scheduler: sequences per-tile k-loops, with at most two finished tiles awaiting drain.
// Optional macro EXE_SCHED_STALL_CNT_EN enables the K_WAIT cycle counter on stall_cnt.
module exe_sched #(
  parameter int K_W = 8,
  parameter int T_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  exe_sched_if.slave  bus,
  output logic [2:0]  state_dbg
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] S_INIT = 3'd1;
  localparam logic [2:0] K_WAIT = 3'd2;
  localparam logic [2:0] K_INIT = 3'd3;
  localparam logic [2:0] K_RUN  = 3'd4;
  localparam logic [2:0] K_FIN  = 3'd5;
  localparam logic [2:0] DRAIN  = 3'd6;
  localparam logic [2:0] DONE   = 3'd7;

  logic [2:0]     state, state_nxt;
  logic [K_W-1:0] k_len_q, k_last, k_cnt_q;
  logic [T_W-1:0] tile_num_q, tile_cnt;
  logic [1:0]     outstanding, out_nxt;
  logic           accept, last_tile, fin_inc, fin_dec, fin_spur;
  logic           s_init_q, k_init_q, k_fin_q, busy_q, done_q, err_q;

  assign accept    = (state == IDLE) && bus.run && (bus.tile_num != '0);
  assign k_last    = (k_len_q == '0) ? '0 : k_len_q - K_W'(1);
  assign last_tile = (tile_cnt == tile_num_q - T_W'(1));

  // A drain pulse coinciding with k_fin is paired with the tile finishing now.
  assign fin_inc  = (state == K_FIN);
  assign fin_spur = bus.out_fin && (outstanding == 2'd0) && !fin_inc;
  assign fin_dec  = bus.out_fin && !fin_spur;

  always_comb begin
    out_nxt = outstanding;
    if (fin_inc && !fin_dec && outstanding != 2'd2)
      out_nxt = outstanding + 2'd1;
    else if (fin_dec && !fin_inc)
      out_nxt = outstanding - 2'd1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = S_INIT;
      S_INIT:  state_nxt = K_WAIT;
      K_WAIT:  if (outstanding < 2'd2) state_nxt = K_INIT;
      K_INIT:  state_nxt = K_RUN;
      K_RUN:   if (k_cnt_q == k_last) state_nxt = K_FIN;
      K_FIN:   state_nxt = last_tile ? DRAIN : K_WAIT;
      DRAIN:   if (outstanding == 2'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      outstanding <= 2'd0;
      k_len_q     <= '0;
      tile_num_q  <= '0;
      tile_cnt    <= '0;
      k_cnt_q     <= '0;
      err_q       <= 1'b0;
      s_init_q    <= 1'b0;
      k_init_q    <= 1'b0;
      k_fin_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      outstanding <= out_nxt;
      if (accept) begin
        k_len_q    <= bus.k_len;
        tile_num_q <= bus.tile_num;
        tile_cnt   <= '0;
      end else if (fin_inc) begin
        tile_cnt <= tile_cnt + T_W'(1);
      end
      if (accept)
        err_q <= 1'b0;
      else if (fin_spur)
        err_q <= 1'b1;
      k_cnt_q  <= (state == K_RUN && state_nxt == K_RUN) ? k_cnt_q + K_W'(1) : '0;
      // Outputs are decoded from the next state so they line up with the state register.
      s_init_q <= (state_nxt == S_INIT);
      k_init_q <= (state_nxt == K_INIT);
      k_fin_q  <= (state_nxt == K_FIN);
      busy_q   <= (state_nxt != IDLE);
      done_q   <= (state_nxt == DONE);
    end
  end

`ifdef EXE_SCHED_STALL_CNT_EN
  logic [15:0] stall_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_q <= 16'd0;
    else if (accept)
      stall_q <= 16'd0;
    else if (state == K_WAIT && stall_q != 16'hFFFF)
      stall_q <= stall_q + 16'd1;
  end
  assign bus.stall_cnt = stall_q;
`else
  assign bus.stall_cnt = 16'd0;
`endif

  assign bus.s_init = s_init_q;
  assign bus.k_init = k_init_q;
  assign bus.k_fin  = k_fin_q;
  assign bus.k_cnt  = k_cnt_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign state_dbg  = state;

endmodule

// File: tb/tb_exe_sched.sv
// Directed bench for exe_sched: job latencies, drain back-pressure, coincident pulses, errors, reset abort.
module tb_exe_sched;
  localparam int K_W = 8;
  localparam int T_W = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] state_dbg;

  exe_sched_if #(.K_W(K_W), .T_W(T_W)) bus ();

  exe_sched #(.K_W(K_W), .T_W(T_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_sinit, n_kinit, n_kfin, n_done;
  int c_sinit, c_kinit, c_kfin, c_done;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // scoreboard: k_fin pulses must land exactly on the queued cycles
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.s_init) begin n_sinit++; c_sinit = cyc; end
      if (bus.k_init) begin n_kinit++; c_kinit = cyc; end
      if (bus.done)   begin n_done++;  c_done  = cyc; end
      if (bus.k_fin) begin
        n_kfin++;
        c_kfin = cyc;
        if (exp_q.size() == 0) check("kfin_extra", 1, 0);
        else check("kfin_cyc", cyc, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic clear_mon();
    n_sinit = 0; n_kinit = 0; n_kfin = 0; n_done = 0;
    c_sinit = -1; c_kinit = -1; c_kfin = -1; c_done = -1;
  endtask

  task automatic start_job(input int k, input int n, output int t);
    bus.run      = 1'b1;
    bus.k_len    = K_W'(k);
    bus.tile_num = T_W'(n);
    t = cyc;
    step();
    bus.run = 1'b0;
  endtask

  task automatic pulse_fin_at(input int c);
    step_to(c);
    bus.out_fin = 1'b1;
    step();
    bus.out_fin = 1'b0;
  endtask

  task automatic wait_kfin(input int n, input int limit);
    int g = 0;
    while (n_kfin < n && g < limit) begin step(); g++; end
    check("wait_kfin", n_kfin, n);
  endtask

  task automatic wait_done(input int limit);
    int g = 0;
    while (n_done == 0 && g < limit) begin step(); g++; end
    check("wait_done", n_done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    int exp_stall;
    rst = 1'b1;
    bus.run = 1'b0; bus.k_len = '0; bus.tile_num = '0; bus.out_fin = 1'b0;
    clear_mon();
    step(); step();
    check("rst_busy",   bus.busy, 0);
    check("rst_sinit",  bus.s_init, 0);
    check("rst_kinit",  bus.k_init, 0);
    check("rst_kfin",   bus.k_fin, 0);
    check("rst_done",   bus.done, 0);
    check("rst_err",    bus.err, 0);
    check("rst_kcnt",   bus.k_cnt, 0);
    check("rst_stall",  bus.stall_cnt, 0);
    check("rst_state",  state_dbg, 0);
    rst = 1'b0;
    step();

    // single tile, k_len=4, drain 3 cycles after k_fin; a run mid-job is ignored
    clear_mon();
    start_job(4, 1, t);
    exp_q.push_back(t + 8);
    step_to(t + 4);
    bus.run = 1'b1; bus.k_len = 8'd9; bus.tile_num = 6'd5;
    step();
    bus.run = 1'b0;
    step_to(t + 6);
    check("j1_kcnt_mid", bus.k_cnt, 2);
    check("j1_busy", bus.busy, 1);
    wait_kfin(1, 30);
    pulse_fin_at(c_kfin + 3);
    wait_done(30);
    check("j1_sinit_cyc", c_sinit, t + 1);
    check("j1_kinit_cyc", c_kinit, t + 3);
    check("j1_done_cyc",  c_done, t + 13);
    check("j1_nkfin", n_kfin, 1);
    check("j1_err", bus.err, 0);
    step();
    check("j1_idle_busy", bus.busy, 0);
    check("j1_pending", exp_q.size(), 0);

    // three tiles, drain withheld: scheduler stalls with two tiles outstanding
    clear_mon();
    start_job(2, 3, t);
    exp_q.push_back(t + 6);
    exp_q.push_back(t + 11);
    exp_q.push_back(t + 23);
    wait_kfin(2, 40);
    step_to(t + 17);
    check("j2_hold_nkfin", n_kfin, 2);
    check("j2_hold_nkinit", n_kinit, 2);
    check("j2_hold_state", state_dbg, 2);
    pulse_fin_at(t + 18);
    wait_kfin(3, 40);
    check("j2_kinit3_cyc", c_kinit, t + 20);
    pulse_fin_at(t + 25);
    pulse_fin_at(t + 27);
    wait_done(30);
    check("j2_done_cyc", c_done, t + 29);
    check("j2_err", bus.err, 0);
`ifdef EXE_SCHED_STALL_CNT_EN
    exp_stall = 10;
`else
    exp_stall = 0;
`endif
    check("j2_stall_cnt", bus.stall_cnt, exp_stall);
    check("j2_pending", exp_q.size(), 0);
    step();

    // drain pulse coincident with the second k_fin
    clear_mon();
    start_job(2, 2, t);
    exp_q.push_back(t + 6);
    exp_q.push_back(t + 11);
    pulse_fin_at(t + 11);
    pulse_fin_at(t + 14);
    wait_done(30);
    check("j3_done_cyc", c_done, t + 16);
    check("j3_nkfin", n_kfin, 2);
    check("j3_err", bus.err, 0);
    check("j3_pending", exp_q.size(), 0);
    step();

    // spurious drain in IDLE, ignored zero-tile run, then k_len=0 job clears err
    clear_mon();
    bus.out_fin = 1'b1;
    step();
    bus.out_fin = 1'b0;
    check("j4_err_set", bus.err, 1);
    check("j4_busy", bus.busy, 0);
    start_job(3, 0, t);
    step(); step();
    check("j4_zero_tile_sinit", n_sinit, 0);
    check("j4_zero_tile_busy", bus.busy, 0);
    check("j4_err_kept", bus.err, 1);
    start_job(0, 1, t);
    check("j4_err_clr", bus.err, 0);
    exp_q.push_back(t + 5);
    wait_kfin(1, 30);
    pulse_fin_at(t + 7);
    wait_done(30);
    check("j4_done_cyc", c_done, t + 9);
    check("j4_pending", exp_q.size(), 0);
    step();

    // reset while k_cnt==3, then a run in the first cycle after release
    clear_mon();
    start_job(8, 1, t);
    step_to(t + 7);
    check("j5_kcnt_pre", bus.k_cnt, 3);
    rst = 1'b1;
    #1;
    check("j5_rst_busy",  bus.busy, 0);
    check("j5_rst_kcnt",  bus.k_cnt, 0);
    check("j5_rst_state", state_dbg, 0);
    check("j5_rst_stall", bus.stall_cnt, 0);
    step();
    rst = 1'b0;
    clear_mon();
    start_job(2, 1, t);
    exp_q.push_back(t + 6);
    wait_kfin(1, 30);
    pulse_fin_at(t + 8);
    wait_done(30);
    check("j5_sinit_cyc", c_sinit, t + 1);
    check("j5_done_cyc", c_done, t + 10);
    check("j5_ndone", n_done, 1);
    check("j5_pending", exp_q.size(), 0);
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
